// File: rtl/ball_ctl.sv
// Pong ball motion/collision controller: steps the ball once per frame, bounces it
// off walls and paddles, and scores misses. All position compares are 12-bit unsigned.
module ball_ctl #(
    parameter int H_RES       = 1024,
    parameter int V_RES       = 768,
    parameter int BALL_SIZE   = 15,
    parameter int PAD_HEIGHT  = 145,
    parameter int PAD_WIDTH   = 15,
    parameter int X_PAD_LEFT  = 30,
    parameter int X_PAD_RIGHT = 979,
    parameter int STEP_X      = 4,
    parameter int STEP_Y      = 3,
    parameter int HOLD_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        serve,
    input  logic [9:0]  y_pad_left,
    input  logic [9:0]  y_pad_right,
    output logic [10:0] x_ball,
    output logic [9:0]  y_ball,
    output logic        in_play,
    output logic        pad_hit,
    output logic        point_left,
    output logic        point_right,
    output logic [1:0]  o_dbg_state
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_MOVE   = 2'd1;
    localparam logic [1:0] S_SCORED = 2'd2;

    localparam int HW = $clog2(HOLD_FRAMES + 1);

    localparam logic [11:0] C_Y_MAX  = 12'(V_RES - 1 - BALL_SIZE);
    localparam logic [11:0] C_X_MAX  = 12'(H_RES - 1 - BALL_SIZE);
    localparam logic [11:0] C_L_FACE = 12'(X_PAD_LEFT + PAD_WIDTH + 1);
    localparam logic [11:0] C_R_FACE = 12'(X_PAD_RIGHT - BALL_SIZE - 1);
    localparam logic [11:0] C_SX     = 12'(STEP_X);
    localparam logic [11:0] C_SY     = 12'(STEP_Y);
    localparam logic [11:0] C_BS     = 12'(BALL_SIZE);
    localparam logic [11:0] C_PH     = 12'(PAD_HEIGHT);
    localparam logic [10:0] X_CTR    = 11'((H_RES - BALL_SIZE - 1) / 2);
    localparam logic [9:0]  Y_CTR    = 10'((V_RES - BALL_SIZE - 1) / 2);

    logic [1:0]    r_state;
    logic [10:0]   r_x;
    logic [9:0]    r_y;
    logic          r_dir_x;   // 1 = right
    logic          r_dir_y;   // 1 = down
    logic [HW-1:0] r_hold;
    logic          r_in_play;
    logic          r_pad_hit;
    logic          r_point_left;
    logic          r_point_right;

    logic [11:0] w_x, w_y, w_pl, w_pr, w_nx, w_ny;
    logic        w_ndx, w_ndy;
    logic        w_hit_l, w_hit_r, w_miss_l, w_miss_r;

    always_comb begin
        w_x  = {1'b0, r_x};
        w_y  = {2'b0, r_y};
        w_pl = {2'b0, y_pad_left};
        w_pr = {2'b0, y_pad_right};

        w_ndy = r_dir_y;
        if (!r_dir_y && (w_y <= C_SY)) begin
            w_ny  = 12'd0;
            w_ndy = 1'b1;
        end else if (r_dir_y && (w_y + C_SY >= C_Y_MAX)) begin
            w_ny  = C_Y_MAX;
            w_ndy = 1'b0;
        end else begin
            w_ny = r_dir_y ? (w_y + C_SY) : (w_y - C_SY);
        end

        // The x windows sit only in front of each face, so a ball that slipped past is never caught from behind.
        w_hit_l  = !r_dir_x && (w_x >= C_L_FACE) && (w_x < C_L_FACE + C_SX)
                   && (w_y + C_BS >= w_pl) && (w_y <= w_pl + C_PH);
        w_hit_r  = r_dir_x && (w_x > C_R_FACE - C_SX) && (w_x <= C_R_FACE)
                   && (w_y + C_BS >= w_pr) && (w_y <= w_pr + C_PH);
        w_miss_l = !w_hit_l && !w_hit_r && !r_dir_x && (w_x <= C_SX);
        w_miss_r = !w_hit_l && !w_hit_r && r_dir_x && (w_x + C_SX >= C_X_MAX);

        w_ndx = r_dir_x;
        if (w_hit_l) begin
            w_nx  = C_L_FACE;
            w_ndx = 1'b1;
        end else if (w_hit_r) begin
            w_nx  = C_R_FACE;
            w_ndx = 1'b0;
        end else begin
            w_nx = r_dir_x ? (w_x + C_SX) : (w_x - C_SX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_x           <= X_CTR;
            r_y           <= Y_CTR;
            r_dir_x       <= 1'b1;
            r_dir_y       <= 1'b1;
            r_hold        <= '0;
            r_in_play     <= 1'b0;
            r_pad_hit     <= 1'b0;
            r_point_left  <= 1'b0;
            r_point_right <= 1'b0;
        end else begin
            r_pad_hit     <= 1'b0;
            r_point_left  <= 1'b0;
            r_point_right <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (serve) begin
                        r_state   <= S_MOVE;
                        r_in_play <= 1'b1;
                    end
                end
                S_MOVE: begin
                    if (frame_tick) begin
                        if (w_miss_l || w_miss_r) begin
                            // Next serve heads toward the player who conceded.
                            r_state       <= S_SCORED;
                            r_in_play     <= 1'b0;
                            r_x           <= X_CTR;
                            r_y           <= Y_CTR;
                            r_dir_x       <= w_miss_r;
                            r_point_left  <= w_miss_r;
                            r_point_right <= w_miss_l;
                        end else begin
                            r_x       <= w_nx[10:0];
                            r_y       <= w_ny[9:0];
                            r_dir_x   <= w_ndx;
                            r_dir_y   <= w_ndy;
                            r_pad_hit <= w_hit_l | w_hit_r;
                        end
                    end
                end
                S_SCORED: begin
                    if (frame_tick) begin
                        if (r_hold == HW'(HOLD_FRAMES - 1)) begin
                            r_state <= S_IDLE;
                            r_hold  <= '0;
                            r_dir_y <= 1'b1;
                        end else begin
                            r_hold <= r_hold + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign x_ball      = r_x;
    assign y_ball      = r_y;
    assign in_play     = r_in_play;
    assign pad_hit     = r_pad_hit;
    assign point_left  = r_point_left;
    assign point_right = r_point_right;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_ball_ctl.sv
// Directed bench for ball_ctl: driver pushes expected output snapshots into a queue,
// a monitor pops and compares them one cycle after the stimulus cycle.
module tb_ball_ctl;
    localparam int EW = 27;
    localparam logic [1:0] ST_IDLE = 2'd0, ST_MOVE = 2'd1, ST_SCORED = 2'd2;

    logic        clk, rst, frame_tick, serve;
    logic [9:0]  y_pad_left, y_pad_right;
    logic [10:0] x_ball;
    logic [9:0]  y_ball;
    logic        in_play, pad_hit, point_left, point_right;
    logic [1:0]  o_dbg_state;

    ball_ctl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .serve(serve),
        .y_pad_left(y_pad_left), .y_pad_right(y_pad_right),
        .x_ball(x_ball), .y_ball(y_ball), .in_play(in_play), .pad_hit(pad_hit),
        .point_left(point_left), .point_right(point_right), .o_dbg_state(o_dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    logic          chk_req, chk_d;
    int            n_checks, n_errors;
    int            ph_cnt, pl_cnt, pr_cnt;

    function automatic logic [EW-1:0] snap(input int x, input int y, input logic ip,
                                           input logic ph, input logic pl, input logic pr,
                                           input logic [1:0] st);
        return {11'(x), 10'(y), ip, ph, pl, pr, st};
    endfunction

    // Monitor: the cycle after a checked stimulus cycle, compare against the queue head.
    always @(posedge clk) chk_d <= chk_req;

    always @(negedge clk) begin
        logic [EW-1:0] act, e;
        string nm;
        if (pad_hit) ph_cnt++;
        if (point_left) pl_cnt++;
        if (point_right) pr_cnt++;
        if (chk_d) begin
            n_checks++;
            act = {x_ball, y_ball, in_play, pad_hit, point_left, point_right, o_dbg_state};
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL underflow: output presented with no expected entry");
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (act !== e) begin
                    n_errors++;
                    $display("FAIL %s: got x=%0d y=%0d ip=%0b ph=%0b pl=%0b pr=%0b st=%0d, want x=%0d y=%0d ip=%0b ph=%0b pl=%0b pr=%0b st=%0d",
                             nm, act[26:16], act[15:6], act[5], act[4], act[3], act[2], act[1:0],
                             e[26:16], e[15:6], e[5], e[4], e[3], e[2], e[1:0]);
                end
            end
        end
    end

    task automatic drive(input logic t, input logic s, input logic r, input logic chk,
                         input logic [EW-1:0] e, input string nm);
        frame_tick = t;
        serve      = s;
        rst        = r;
        chk_req    = chk;
        if (chk) begin
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
        @(negedge clk);
    endtask

    task automatic go(input logic t, input logic s, input logic r);
        drive(t, s, r, 1'b0, '0, "");
    endtask

    task automatic expect_after(input logic t, input logic s, input logic r,
                                input logic [EW-1:0] e, input string nm);
        drive(t, s, r, 1'b1, e, nm);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            go(1'b1, 1'b0, 1'b0);
            go(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic tick_chk(input logic [EW-1:0] e, input string nm);
        expect_after(1'b1, 1'b0, 1'b0, e, nm);
        go(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        go(1'b0, 1'b0, 1'b1);
        go(1'b0, 1'b0, 1'b1);
        go(1'b0, 1'b0, 1'b0);
    endtask

    task automatic count_chk(input string nm, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d", nm, act, want);
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0; ph_cnt = 0; pl_cnt = 0; pr_cnt = 0;
        rst = 1'b1; frame_tick = 1'b0; serve = 1'b0; chk_req = 1'b0; chk_d = 1'b0;
        y_pad_left = 10'd0; y_pad_right = 10'd0;
        @(negedge clk);

        // Reset, then idle ticks leave the ball parked.
        expect_after(1'b0, 1'b0, 1'b1, snap(504, 376, 0, 0, 0, 0, ST_IDLE), "reset_state");
        go(1'b0, 1'b0, 1'b0);
        ticks(9);
        tick_chk(snap(504, 376, 0, 0, 0, 0, ST_IDLE), "idle_10_ticks");

        // Serve then first move; serve+tick in the same cycle does not move.
        do_reset();
        expect_after(1'b0, 1'b1, 1'b0, snap(504, 376, 1, 0, 0, 0, ST_MOVE), "serve_enter_move");
        tick_chk(snap(508, 379, 1, 0, 0, 0, ST_MOVE), "first_move");
        do_reset();
        expect_after(1'b1, 1'b1, 1'b0, snap(504, 376, 1, 0, 0, 0, ST_MOVE), "serve_tick_same_cycle");
        go(1'b0, 1'b0, 1'b0);
        tick_chk(snap(508, 379, 1, 0, 0, 0, ST_MOVE), "move_after_joint_serve");

        // Right pad hit, bottom wall, then left pad hit; a serve mid-flight is ignored.
        y_pad_right = 10'd600; y_pad_left = 10'd0;
        do_reset();
        go(1'b0, 1'b1, 1'b0);
        ticks(113);
        tick_chk(snap(960, 718, 1, 0, 0, 0, ST_MOVE), "tick114_before_pad");
        expect_after(1'b1, 1'b0, 1'b0, snap(963, 721, 1, 1, 0, 0, ST_MOVE), "right_pad_hit");
        expect_after(1'b0, 1'b0, 1'b0, snap(963, 721, 1, 0, 0, 0, ST_MOVE), "pad_hit_one_cycle");
        tick_chk(snap(959, 724, 1, 0, 0, 0, ST_MOVE), "after_right_bounce");
        ticks(9);
        tick_chk(snap(919, 752, 1, 0, 0, 0, ST_MOVE), "bottom_wall");
        tick_chk(snap(915, 749, 1, 0, 0, 0, ST_MOVE), "after_bottom_wall");
        ticks(100);
        go(1'b1, 1'b1, 1'b0);
        go(1'b0, 1'b0, 1'b0);
        ticks(116);
        tick_chk(snap(46, 95, 1, 1, 0, 0, ST_MOVE), "left_pad_hit");
        tick_chk(snap(50, 92, 1, 0, 0, 0, ST_MOVE), "after_left_bounce");

        // Right miss, hold period with an ignored serve, then serve to the right.
        y_pad_right = 10'd0; y_pad_left = 10'd0;
        do_reset();
        go(1'b0, 1'b1, 1'b0);
        ticks(114);
        tick_chk(snap(964, 721, 1, 0, 0, 0, ST_MOVE), "right_pass_no_hit");
        ticks(9);
        tick_chk(snap(1004, 751, 1, 0, 0, 0, ST_MOVE), "tick125_near_edge");
        expect_after(1'b1, 1'b0, 1'b0, snap(504, 376, 0, 0, 1, 0, ST_SCORED), "right_miss_point_left");
        expect_after(1'b0, 1'b1, 1'b0, snap(504, 376, 0, 0, 0, 0, ST_SCORED), "serve_in_scored_ignored");
        ticks(58);
        tick_chk(snap(504, 376, 0, 0, 0, 0, ST_SCORED), "hold_59");
        tick_chk(snap(504, 376, 0, 0, 0, 0, ST_IDLE), "hold_60_idle");
        expect_after(1'b0, 1'b1, 1'b0, snap(504, 376, 1, 0, 0, 0, ST_MOVE), "reserve_after_left_point");
        tick_chk(snap(508, 379, 1, 0, 0, 0, ST_MOVE), "serve_dir_right");

        // Left miss: ball bounces off right pad, misses the left pad, then serves left.
        y_pad_right = 10'd600; y_pad_left = 10'd600;
        do_reset();
        go(1'b0, 1'b1, 1'b0);
        ticks(344);
        tick_chk(snap(43, 95, 1, 0, 0, 0, ST_MOVE), "left_pass_no_hit");
        ticks(9);
        tick_chk(snap(3, 65, 1, 0, 0, 0, ST_MOVE), "tick355_near_edge");
        tick_chk(snap(504, 376, 0, 0, 0, 1, ST_SCORED), "left_miss_point_right");
        ticks(59);
        tick_chk(snap(504, 376, 0, 0, 0, 0, ST_IDLE), "hold_done_idle");
        go(1'b0, 1'b1, 1'b0);
        tick_chk(snap(500, 379, 1, 0, 0, 0, ST_MOVE), "serve_dir_left");

        // Reset mid-flight aborts to the parked state.
        do_reset();
        go(1'b0, 1'b1, 1'b0);
        ticks(49);
        expect_after(1'b1, 1'b0, 1'b1, snap(504, 376, 0, 0, 0, 0, ST_IDLE), "reset_mid_move");
        ticks(3);
        expect_after(1'b0, 1'b0, 1'b0, snap(504, 376, 0, 0, 0, 0, ST_IDLE), "idle_after_mid_reset");

        go(1'b0, 1'b0, 1'b0);
        go(1'b0, 1'b0, 1'b0);
        count_chk("pad_hit_pulses", ph_cnt, 3);
        count_chk("point_left_pulses", pl_cnt, 1);
        count_chk("point_right_pulses", pr_cnt, 1);
        count_chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
